// File: rtl/mem_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_pkg : size encodings, FSM states and lane helpers for data-memory access
// Rev 1.0
// ----------------------------------------------------------------------------
package mem_pkg;

   localparam int LANE_W = 32;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RD     = 2'b01,
      RMW_RD = 2'b10,
      WR     = 2'b11
   } state_t;

   function automatic logic is_misaligned(input logic [1:0] off, input logic [1:0] size);
      logic bad;
      bad = 1'b1;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = off[0];
         SZ_WORD: bad = |off;
         SZ_ILL:  bad = 1'b1;
      endcase
      return bad;
   endfunction

   function automatic logic [LANE_W-1:0] lane_extract(input logic [LANE_W-1:0] word,
                                                       input logic [1:0]        off,
                                                       input logic [1:0]        size,
                                                       input logic              uns);
      logic [7:0]        b;
      logic [15:0]       h;
      logic [LANE_W-1:0] r;
      case (off)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = off[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_BYTE: r = {{24{b[7] & ~uns}}, b};
         SZ_HALF: r = {{16{h[15] & ~uns}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   function automatic logic [LANE_W-1:0] lane_merge(input logic [LANE_W-1:0] word,
                                                     input logic [LANE_W-1:0] wdata,
                                                     input logic [1:0]        off,
                                                     input logic [1:0]        size);
      logic [LANE_W-1:0] r;
      r = word;
      case (size)
         SZ_BYTE: begin
            case (off)
               2'd0:    r[7:0]   = wdata[7:0];
               2'd1:    r[15:8]  = wdata[7:0];
               2'd2:    r[23:16] = wdata[7:0];
               default: r[31:24] = wdata[7:0];
            endcase
         end
         SZ_HALF: begin
            if (off[1]) r[31:16] = wdata[15:0];
            else        r[15:0]  = wdata[15:0];
         end
         default: r = wdata;
      endcase
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_lane_align : combinational load extract/extend and store lane merge
// Rev 1.0
// ----------------------------------------------------------------------------
module mem_lane_align
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [1:0]            offset,
   input  logic [1:0]            size,
   input  logic                  is_unsigned,
   input  logic [DATA_WIDTH-1:0] rd_word,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0] load_data,
   output logic [DATA_WIDTH-1:0] merge_data
);

   assign load_data  = lane_extract(rd_word, offset, size, is_unsigned);
   assign merge_data = lane_merge(rd_word, wr_data, offset, size);

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_access_unit : byte/half/word load-store initiator with RMW sub-word stores
// Rev 1.0
// ----------------------------------------------------------------------------
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH+1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic                  rsp_err,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data,
   output logic                  mem_write,
   output logic                  mem_read,
   input  logic [DATA_WIDTH-1:0] mem_q
);

   state_t                state_q,     state_d;
   logic [ADDR_WIDTH+1:0] addr_q,      addr_d;
   logic [1:0]            size_q,      size_d;
   logic                  unsigned_q,  unsigned_d;
   logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;
   logic [DATA_WIDTH-1:0] merge_q,     merge_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_err_q,   rsp_err_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

   logic [DATA_WIDTH-1:0] load_data;
   logic [DATA_WIDTH-1:0] merge_data;

   mem_lane_align #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_lane_align (
      .offset      (addr_q[1:0]),
      .size        (size_q),
      .is_unsigned (unsigned_q),
      .rd_word     (mem_q),
      .wr_data     (wdata_q),
      .load_data   (load_data),
      .merge_data  (merge_data)
   );

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      size_d      = size_q;
      unsigned_d  = unsigned_q;
      wdata_d     = wdata_q;
      merge_d     = merge_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = '0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d     = req_addr;
               size_d     = req_size;
               unsigned_d = req_unsigned;
               wdata_d    = req_wdata;
               if (is_misaligned(req_addr[1:0], req_size)) begin
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end else if (!req_write) begin
                  state_d = RD;
               end else if (req_size == SZ_WORD) begin
                  merge_d = req_wdata;
                  state_d = WR;
               end else begin
                  state_d = RMW_RD;
               end
            end
         end
         RD: begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = load_data;
            state_d     = IDLE;
         end
         RMW_RD: begin
            merge_d = merge_data;
            state_d = WR;
         end
         WR: begin
            rsp_valid_d = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         size_q      <= SZ_BYTE;
         unsigned_q  <= 1'b0;
         wdata_q     <= '0;
         merge_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         size_q      <= size_d;
         unsigned_q  <= unsigned_d;
         wdata_q     <= wdata_d;
         merge_q     <= merge_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   // Strobes also gate on rst_n so a pending negedge write is dropped at once.
   assign req_ready = (state_q == IDLE);
   assign mem_read  = rst_n && ((state_q == RD) || (state_q == RMW_RD));
   assign mem_write = rst_n && (state_q == WR);
   assign mem_addr  = (state_q != IDLE) ? addr_q[ADDR_WIDTH+1:2] : '0;
   assign mem_data  = (state_q == WR) ? merge_q : '0;

   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_access_unit : directed + random load/store bench with reference memory
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mem_access_unit;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [7:0]  req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_err;
   logic [31:0] rsp_rdata;
   logic [5:0]  mem_addr;
   logic [31:0] mem_data;
   logic        mem_write;
   logic        mem_read;
   logic [31:0] mem_q;

   logic [31:0] dut_mem [64];
   logic [31:0] ref_mem [64];
   logic        pl_en;
   logic [5:0]  pl_addr;
   logic [31:0] pl_data;

   int total;
   int bad;
   int rd_cnt;
   int wr_cnt;
   int both_cnt;

   mem_access_unit #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (6)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_err      (rsp_err),
      .rsp_rdata    (rsp_rdata),
      .mem_addr     (mem_addr),
      .mem_data     (mem_data),
      .mem_write    (mem_write),
      .mem_read     (mem_read),
      .mem_q        (mem_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Data memory: async read, write on negedge; preload port has priority.
   assign mem_q = dut_mem[mem_addr];
   always @(negedge clk) begin
      if (mem_read)              rd_cnt++;
      if (mem_write)             wr_cnt++;
      if (mem_read && mem_write) both_cnt++;
      if (pl_en)                 dut_mem[pl_addr] = pl_data;
      else if (mem_write)        dut_mem[mem_addr] = mem_data;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic ref_misaligned(input logic [1:0] sz, input logic [7:0] a);
      return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [7:0] a,
                                            input logic [1:0] sz, input logic uns);
      logic [31:0] v;
      int          sh;
      sh = int'(a % 4) * 8;
      v  = word >> sh;
      if (sz == 2'd0) begin
         v = v & 32'hFF;
         if (!uns && v >= 32'd128) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
         v = v & 32'hFFFF;
         if (!uns && v >= 32'd32768) v = v | 32'hFFFF_0000;
      end else begin
         v = word;
      end
      return v;
   endfunction

   function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [7:0] a, input logic [1:0] sz);
      logic [31:0] m;
      int          sh;
      sh = int'(a % 4) * 8;
      m  = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
      m  = m << sh;
      return (old & ~m) | ((wd << sh) & m);
   endfunction

   task automatic preload(input int idx, input logic [31:0] val);
      pl_en   = 1'b1;
      pl_addr = 6'(idx);
      pl_data = val;
      ref_mem[idx] = val;
      @(negedge clk);
      #1;
      pl_en = 1'b0;
   endtask

   task automatic issue(input string tag, input logic w, input logic [1:0] sz,
                        input logic uns, input logic [7:0] a, input logic [31:0] wd);
      logic        e_err;
      logic [31:0] e_rdata;
      int          e_lat, e_rd, e_wr, widx, lat, rd0, wr0;
      widx    = int'(a / 4);
      e_err   = ref_misaligned(sz, a);
      e_rdata = 32'h0;
      if (e_err) begin
         e_lat = 1; e_rd = 0; e_wr = 0;
      end else if (!w) begin
         e_lat = 2; e_rd = 1; e_wr = 0;
         e_rdata = ref_load(ref_mem[widx], a, sz, uns);
      end else begin
         e_lat = (sz == 2'd2) ? 2 : 3;
         e_rd  = (sz == 2'd2) ? 0 : 1;
         e_wr  = 1;
         ref_mem[widx] = ref_store(ref_mem[widx], wd, a, sz);
      end
      @(negedge clk);
      check({tag, ".ready"}, 32'(req_ready), 32'd1);
      req_valid    = 1'b1;
      req_write    = w;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = a;
      req_wdata    = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      lat = 1;
      if (!e_err) check({tag, ".busy"}, 32'(req_ready), 32'd0);
      while (!rsp_valid && lat < 8) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, ".lat"},   32'(lat),          32'(e_lat));
      check({tag, ".err"},   32'(rsp_err),      32'(e_err));
      check({tag, ".rdata"}, rsp_rdata,         e_rdata);
      check({tag, ".nrd"},   32'(rd_cnt - rd0), 32'(e_rd));
      check({tag, ".nwr"},   32'(wr_cnt - wr0), 32'(e_wr));
      if (w && !e_err) check({tag, ".memw"}, dut_mem[widx], ref_mem[widx]);
   endtask

   task automatic pulse_gone(input string tag);
      @(posedge clk);
      #1;
      check({tag, ".pulse"}, 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      logic        w, uns;
      logic [1:0]  sz;
      logic [7:0]  a;
      logic [31:0] wd;
      int          wr0;
      total = 0; bad = 0; rd_cnt = 0; wr_cnt = 0; both_cnt = 0;
      pl_en = 1'b0; pl_addr = '0; pl_data = '0;
      rst_n = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
      req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;

      for (int i = 0; i < 64; i++) preload(i, $urandom);
      check("rst.ready",   32'(req_ready), 32'd1);
      check("rst.valid",   32'(rsp_valid), 32'd0);
      check("rst.err",     32'(rsp_err),   32'd0);
      check("rst.rdata",   rsp_rdata,      32'd0);
      check("rst.mread",   32'(mem_read),  32'd0);
      check("rst.mwrite",  32'(mem_write), 32'd0);
      check("rst.maddr",   32'(mem_addr),  32'd0);
      check("rst.mdata",   mem_data,       32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      preload(3, 32'h8899_AABB);
      issue("lb",  1'b0, 2'd0, 1'b0, 8'h0D, 32'h0);
      check("lb.const", rsp_rdata, 32'hFFFF_FFAA);
      pulse_gone("lb");
      issue("lbu", 1'b0, 2'd0, 1'b1, 8'h0D, 32'h0);
      check("lbu.const", rsp_rdata, 32'h0000_00AA);
      issue("sh",  1'b1, 2'd1, 1'b0, 8'h0E, 32'h0000_1234);
      check("sh.const", dut_mem[3], 32'h1234_AABB);
      pulse_gone("sh");
      issue("lh_hi", 1'b0, 2'd1, 1'b0, 8'h0E, 32'h0);
      issue("sw",  1'b1, 2'd2, 1'b0, 8'h10, 32'hDEAD_BEEF);
      issue("lw",  1'b0, 2'd2, 1'b0, 8'h10, 32'h0);
      check("lw.const", rsp_rdata, 32'hDEAD_BEEF);
      issue("lw_mis", 1'b0, 2'd2, 1'b0, 8'h11, 32'h0);
      issue("lh_mis", 1'b0, 2'd1, 1'b0, 8'h03, 32'h0);
      issue("sz_ill", 1'b0, 2'd3, 1'b0, 8'h00, 32'h0);
      issue("sw_mis", 1'b1, 2'd2, 1'b0, 8'h22, 32'h1111_2222);
      pulse_gone("err");

      // Back-to-back: the lw is presented in the sw response cycle.
      issue("b2b_sw", 1'b1, 2'd2, 1'b0, 8'h20, 32'hCAFE_F00D);
      issue("b2b_lw", 1'b0, 2'd2, 1'b0, 8'h20, 32'h0);
      issue("b2b_sb", 1'b1, 2'd0, 1'b0, 8'h23, 32'h0000_0077);
      issue("b2b_lb", 1'b0, 2'd0, 1'b1, 8'h23, 32'h0);

      // Reset during WR of a sub-word store, before the write negedge.
      preload(0, 32'h1122_3344);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0;
      req_unsigned = 1'b0; req_addr = 8'h00; req_wdata = 32'h0000_00AB;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      check("abort.inwr", 32'(mem_write), 32'd1);
      wr0 = wr_cnt;
      rst_n = 1'b0;
      #1;
      check("abort.mwrite", 32'(mem_write), 32'd0);
      check("abort.mread",  32'(mem_read),  32'd0);
      check("abort.maddr",  32'(mem_addr),  32'd0);
      check("abort.mdata",  mem_data,       32'd0);
      check("abort.ready",  32'(req_ready), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      check("abort.valid",  32'(rsp_valid), 32'd0);
      check("abort.nwr",    32'(wr_cnt - wr0), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      check("abort.word0",  dut_mem[0], 32'h1122_3344);
      issue("abort.lw", 1'b0, 2'd2, 1'b0, 8'h00, 32'h0);

      for (int i = 0; i < 80; i++) begin
         w   = 1'($urandom_range(0, 1));
         sz  = 2'($urandom_range(0, 3));
         uns = 1'($urandom_range(0, 1));
         a   = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 3) != 0) a = a & ((sz == 2'd2) ? 8'hFC : (sz == 2'd1) ? 8'hFE : 8'hFF);
         wd  = $urandom;
         issue("rnd", w, sz, uns, a, wd);
      end

      for (int i = 0; i < 64; i++) check("final.mem", dut_mem[i], ref_mem[i]);
      check("final.excl", 32'(both_cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data-memory interface: sits between the pipeline MEM stage and the word-wide, negedge-write, async-read data memory.
- Turns byte-addressed load/store requests of byte, halfword or word size into word-level memory accesses.
- Sub-word stores use an internal read-modify-write sequence.
- Loads are lane-extracted and sign- or zero-extended. Misaligned accesses are rejected without touching memory.

Parameters:
- DATA_WIDTH, 32, memory word width; fixed at 32 for lane logic.
- ADDR_WIDTH, 6, word-address width of the data memory; the byte address is ADDR_WIDTH+2 bits.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (state IDLE).
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_WIDTH+2  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_err  out  1  valid with rsp_valid; misaligned or illegal size.
- rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- mem_addr  out  ADDR_WIDTH  word address to memory.
- mem_data  out  DATA_WIDTH  write data to memory.
- mem_write  out  1  memory write enable (memory samples on negedge).
- mem_read  out  1  memory read strobe.
- mem_q  in  DATA_WIDTH  combinational read data from memory.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, latched request cleared, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_write=0, mem_read=0, mem_addr=0, mem_data=0.
- Reset mid-operation aborts immediately. mem_write drops combinationally, so a WR whose negedge has not yet occurred does not write. No response is produced for the aborted request.
- Byte order is little-endian: offset 0 → bits [7:0], offset 3 → [31:24]. Halfword offset 0 → [15:0], offset 2 → [31:16].
- Alignment: half needs addr[0]=0; word needs addr[1:0]=00; size 11 is always an error.
- Word address = req_addr[ADDR_WIDTH+1:2]. There is no wrap logic beyond natural truncation.
- Memory-side outputs are combinational decodes of the state and the latched request registers only, never of req_* inputs.
- req_ready = (state==IDLE). A request is accepted on a posedge with req_valid & req_ready; all req_* fields are latched.
- States and transitions:
  - IDLE, accepted request:
    - misaligned/illegal → stay IDLE; next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0. 1-cycle latency, ready remains high.
    - load → RD.
    - word store → WR, mem_data = req_wdata.
    - byte/half store → RMW_RD.
  - RD: mem_read=1, mem_addr=latched word addr. At posedge, extract the lane from mem_q and extend per size/unsigned into rsp_rdata; rsp_valid=1 next cycle; → IDLE.
  - RMW_RD: mem_read=1. At posedge, register merge word = mem_q with the addressed byte/half lanes replaced by wdata[7:0]/[15:0]; → WR.
  - WR: mem_write=1, mem_data = merge (or wdata for word stores); memory writes on this cycle's negedge. At posedge → IDLE; rsp_valid=1, rsp_err=0, rsp_rdata=0 next cycle.
- Latencies (accept edge to rsp_valid cycle): error 1, load 2, word store 2, sub-word store 3.
- rsp_valid is a single-cycle pulse, with no backpressure on the response.
- A new request may be accepted in the same cycle rsp_valid is high (state already IDLE).
- mem_write and mem_read are never both high.
- Sign extension copies bit 7 (byte) or bit 15 (half) into all upper bits.

Decomposition:
- Shared package mem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL;
  - state enum (IDLE, RD, RMW_RD, WR);
  - lane-extract and lane-merge functions reused by other pipeline code.
- One natural sub-module: mem_lane_align, purely combinational. It performs extract+extend (load path) and merge (store path) from offset and size, and is instantiated once inside the FSM.

Test Plan:
- Preload word 3 = 0x8899AABB; lb addr 0x0D → rsp_rdata=0xFFFFFFAA, err=0, rsp_valid 2 cycles after accept; lbu same → 0x000000AA.
- Word 3 = 0x8899AABB; sh addr 0x0E, wdata 0x00001234 → RMW_RD then WR, memory word 3 = 0x1234AABB; rsp_valid 3 cycles after accept; no write strobe outside WR.
- sw addr 0x10, wdata 0xDEADBEEF → single WR cycle, memory word 4 = 0xDEADBEEF, no mem_read asserted; lw addr 0x10 → 0xDEADBEEF.
- lw addr 0x11 and lh addr 0x03 and size 11 → rsp_err=1 one cycle after accept, rdata=0, mem_read/mem_write never asserted, req_ready stays 1.
- Assert rst_n=0 during WR of sb addr 0x00 (before negedge) → memory word 0 unchanged, all outputs 0 immediately, no rsp_valid; after release a lw addr 0x00 completes normally.
- Back-to-back: lw accepted in the cycle rsp_valid of the prior sw is high → both complete in order, req_ready low only while in RD/RMW_RD/WR.
